// File: rtl/mix_col_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mix_col_seq
// Description : Sequential AES MixColumns / InvMixColumns / bypass engine.
//               Processes COLS_PER_CYCLE columns per clock in place inside a
//               128-bit working register, with valid/ready on both sides.
// Revision    : 1.0 - initial release
// ============================================================================
module mix_col_seq #(
   parameter int COLS_PER_CYCLE = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] data_in,
   input  logic [1:0]   mode,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] data_out,
   output logic         busy
);

   // Only 1, 2 and 4 split the four columns into whole steps.
   if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
      $error("mix_col_seq: COLS_PER_CYCLE must be 1, 2 or 4");
   end

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BUSY = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Column index advance per step; for 4 columns this wraps to 0.
   localparam logic [1:0] c_step     = 2'(COLS_PER_CYCLE);
   // Column index of the step that finishes column 3.
   localparam logic [1:0] c_last_idx = 2'(4 - COLS_PER_CYCLE);

   logic [1:0]   state_q,   state_d;
   logic [1:0]   col_idx_q, col_idx_d;
   logic [1:0]   mode_q,    mode_d;
   logic [127:0] work_q,    work_d;

   logic         w_accept;
   logic         w_last_step;
   logic [1:0]   w_slice_col [COLS_PER_CYCLE];
   logic [31:0]  w_slice_in  [COLS_PER_CYCLE];
   logic [31:0]  w_slice_out [COLS_PER_CYCLE];

   // GF(2^8) multiply by 2 modulo 0x11B.
   function automatic logic [7:0] xt(input logic [7:0] x);
      return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
   endfunction

   // One column: forward mix, inverse mix, or copy when mode[1] is set.
   function automatic logic [31:0] mix_word(input logic [31:0] col, input logic [1:0] m);
      logic [7:0] a [4];
      logic [7:0] x2 [4];
      logic [7:0] x4 [4];
      logic [7:0] x8 [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] m3 [4];
      logic [31:0] res;
      for (int r = 0; r < 4; r++) begin
         a[r]  = col[31-8*r -: 8];
         x2[r] = xt(a[r]);
         x4[r] = xt(x2[r]);
         x8[r] = xt(x4[r]);
         m3[r] = x2[r] ^ a[r];
         m9[r] = x8[r] ^ a[r];
         mb[r] = x8[r] ^ x2[r] ^ a[r];
         md[r] = x8[r] ^ x4[r] ^ a[r];
         me[r] = x8[r] ^ x4[r] ^ x2[r];
      end
      if (m[1]) begin
         res = col;
      end else if (m[0]) begin
         res = {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
      end else begin
         res = {x2[0] ^ m3[1] ^ a[2]  ^ a[3],
                a[0]  ^ x2[1] ^ m3[2] ^ a[3],
                a[0]  ^ a[1]  ^ x2[2] ^ m3[3],
                m3[0] ^ a[1]  ^ a[2]  ^ x2[3]};
      end
      return res;
   endfunction

   // Shared column slices: slice s works on column col_idx + s.
   for (genvar s = 0; s < COLS_PER_CYCLE; s++) begin : g_slice
      assign w_slice_col[s] = col_idx_q + 2'(s);
      assign w_slice_in[s]  = work_q[{w_slice_col[s], 5'b0} +: 32];
      assign w_slice_out[s] = mix_word(w_slice_in[s], mode_q);
   end

   assign w_accept    = in_valid && in_ready;
   assign w_last_step = (col_idx_q == c_last_idx);

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic: accept -> BUSY, last column step -> DONE, drain -> IDLE.
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: if (w_accept) state_d = ST_BUSY;
         ST_BUSY: if (w_last_step) state_d = ST_DONE;
         ST_DONE: begin
            if (w_accept) begin
               state_d = ST_BUSY;
            end else if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output logic; a new block may be taken in the DONE cycle it drains.
   always_comb begin
      in_ready  = !rst && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready));
      out_valid = (state_q == ST_DONE);
      busy      = (state_q == ST_BUSY);
      data_out  = work_q;
   end

   // Datapath next values: load on accept, write mixed columns back while busy.
   always_comb begin
      work_d    = work_q;
      mode_d    = mode_q;
      col_idx_d = col_idx_q;
      if (w_accept) begin
         work_d    = data_in;
         mode_d    = mode;
         col_idx_d = 2'd0;
      end else if (state_q == ST_BUSY) begin
         for (int s = 0; s < COLS_PER_CYCLE; s++) begin
            work_d[{w_slice_col[s], 5'b0} +: 32] = w_slice_out[s];
         end
         col_idx_d = col_idx_q + c_step;
      end
   end

   // Datapath registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         work_q    <= '0;
         mode_q    <= 2'b00;
         col_idx_q <= 2'd0;
      end else begin
         work_q    <= work_d;
         mode_q    <= mode_d;
         col_idx_q <= col_idx_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mix_col_seq.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mix_col_seq
// Description : Self-checking bench for mix_col_seq at COLS_PER_CYCLE 1, 2, 4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mix_col_seq;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic         iv   [3];
   logic         ir   [3];
   logic         ov   [3];
   logic         ordy [3];
   logic         bsy  [3];
   logic [127:0] din  [3];
   logic [127:0] dout [3];
   logic [1:0]   md   [3];

   int n_cmp  = 0;
   int n_fail = 0;

   for (genvar k = 0; k < 3; k++) begin : g_dut
      localparam int P = (k == 0) ? 1 : ((k == 1) ? 2 : 4);
      mix_col_seq #(.COLS_PER_CYCLE(P)) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (iv[k]),
         .in_ready  (ir[k]),
         .data_in   (din[k]),
         .mode      (md[k]),
         .out_valid (ov[k]),
         .out_ready (ordy[k]),
         .data_out  (dout[k]),
         .busy      (bsy[k])
      );
   end

   typedef struct {
      logic [1:0]   m;
      logic [127:0] d;
      logic [127:0] e;
   } vec_t;
   vec_t tbl [5];

   function automatic int lat_of(input int k);
      return (k == 0) ? 4 : ((k == 1) ? 2 : 1);
   endfunction

   // Carry-less product then reduction by the AES polynomial.
   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      int p = 0;
      for (int i = 0; i < 8; i++) if (b[i]) p = p ^ (int'(a) << i);
      for (int i = 14; i >= 8; i--) if (p[i]) p = p ^ (32'h11b << (i - 8));
      return p[7:0];
   endfunction

   // Whole-block reference: circulant coefficient matrix per column.
   function automatic logic [127:0] ref_block(input logic [1:0] m, input logic [127:0] d);
      logic [7:0]   cf [4];
      logic [127:0] r;
      logic [7:0]   acc;
      if (m[1]) return d;
      if (m[0]) cf = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
      else      cf = '{8'h02, 8'h03, 8'h01, 8'h01};
      r = '0;
      for (int c = 0; c < 4; c++) begin
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int j = 0; j < 4; j++)
               acc = acc ^ gmul(cf[(j - row + 4) % 4], d[c*32+31-8*j -: 8]);
            r[c*32+31-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [127:0] rnd128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Single block with latency, busy-length and result checks.
   task automatic do_block(input int k, input logic [1:0] m, input logic [127:0] d,
                           input logic [127:0] exp, input string nm);
      int lat = 0;
      int bc  = 0;
      @(posedge clk); #1;
      iv[k] = 1'b1; md[k] = m; din[k] = d; ordy[k] = 1'b1;
      chk({nm, " in_ready"}, 128'(ir[k]), 128'd1);
      @(posedge clk); #1;
      iv[k] = 1'b0; md[k] = 2'($urandom); din[k] = rnd128();
      while (!ov[k] && lat < 10) begin
         if (bsy[k]) bc++;
         @(posedge clk); #1;
         lat++;
      end
      chk({nm, " latency"}, 128'(lat), 128'(lat_of(k)));
      chk({nm, " busy cycles"}, 128'(bc), 128'(lat_of(k)));
      chk({nm, " data"}, dout[k], exp);
   endtask

   // Streaming run against a queue-based scoreboard.
   task automatic run_stream(input int k, input int nblk, input bit rnd);
      logic [127:0] exp_q [$];
      int           acc_q [$];
      int cyc = 0, acc = 0, got = 0, last_acc = -1;
      int limit = 60 * nblk + 100;
      logic [1:0] m = 2'b00;
      while (got < nblk && cyc < limit) begin
         @(posedge clk); #1;
         cyc++;
         if (rnd) begin
            iv[k]   = (acc < nblk) && ($urandom_range(0, 3) != 0);
            ordy[k] = ($urandom_range(0, 3) != 0);
            md[k]   = 2'($urandom);
         end else begin
            iv[k]   = (acc < nblk);
            ordy[k] = 1'b1;
            md[k]   = m;
         end
         din[k] = rnd128();
         @(negedge clk);
         if (ov[k] && ordy[k]) begin
            if (exp_q.size() == 0) begin
               chk($sformatf("stream k%0d spurious output", k), 128'd1, 128'd0);
            end else begin
               chk($sformatf("stream k%0d blk%0d data", k, got), dout[k], exp_q.pop_front());
               if (!rnd)
                  chk($sformatf("stream k%0d blk%0d latency", k, got),
                      128'(cyc - acc_q[0]), 128'(lat_of(k) + 1));
               void'(acc_q.pop_front());
            end
            got++;
         end
         if (iv[k] && ir[k]) begin
            exp_q.push_back(ref_block(md[k], din[k]));
            acc_q.push_back(cyc);
            if (!rnd && last_acc >= 0)
               chk($sformatf("stream k%0d accept interval", k),
                   128'(cyc - last_acc), 128'(lat_of(k) + 1));
            last_acc = cyc;
            acc++;
            m = (m == 2'b00) ? 2'b01 : 2'b00;
         end
      end
      iv[k] = 1'b0;
      chk($sformatf("stream k%0d outputs seen", k), 128'(got), 128'(nblk));
      chk($sformatf("stream k%0d pending left", k), 128'(exp_q.size()), 128'd0);
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [127:0] d, f;
      int           wcnt;

      tbl[0] = '{2'b00, 128'hc6c6c6c6_01010101_f20a225c_db135345,
                        128'hc6c6c6c6_01010101_9fdc589d_8e4da1bc};
      tbl[1] = '{2'b01, 128'h9fdc589d_8e4da1bc_4d7ebdf8_d5d5d7d6,
                        128'hf20a225c_db135345_2d26314c_d4d4d4d5};
      tbl[2] = '{2'b10, 128'h01234567_89abcdef_fedcba98_76543210,
                        128'h01234567_89abcdef_fedcba98_76543210};
      tbl[3] = '{2'b11, 128'hdeadbeef_00ff00ff_13579bdf_2468ace0,
                        128'hdeadbeef_00ff00ff_13579bdf_2468ace0};
      tbl[4] = '{2'b00, 128'h0, 128'h0};

      rst = 1'b1;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; din[k] = '0; md[k] = 2'b00;
      end

      // Reset values.
      repeat (2) @(posedge clk);
      #1;
      for (int k = 0; k < 3; k++) begin
         chk($sformatf("reset k%0d out_valid", k), 128'(ov[k]), 128'd0);
         chk($sformatf("reset k%0d busy", k), 128'(bsy[k]), 128'd0);
         chk($sformatf("reset k%0d data_out", k), dout[k], 128'd0);
         chk($sformatf("reset k%0d in_ready", k), 128'(ir[k]), 128'd0);
      end
      rst = 1'b0;
      #1;
      for (int k = 0; k < 3; k++)
         chk($sformatf("post-reset k%0d in_ready", k), 128'(ir[k]), 128'd1);

      // Known-answer vectors on every width.
      for (int k = 0; k < 3; k++)
         for (int i = 0; i < 5; i++)
            do_block(k, tbl[i].m, tbl[i].d, tbl[i].e, $sformatf("tbl k%0d v%0d", k, i));

      // Forward then inverse returns the original block.
      for (int i = 0; i < 6; i++) begin
         d = rnd128();
         f = ref_block(2'b00, d);
         do_block(i % 3, 2'b00, d, f, $sformatf("roundtrip%0d fwd", i));
         do_block(i % 3, 2'b01, f, d, $sformatf("roundtrip%0d inv", i));
      end

      // Reset one cycle after accept discards the block.
      @(posedge clk); #1;
      iv[0] = 1'b1; md[0] = 2'b00; din[0] = rnd128(); ordy[0] = 1'b1;
      @(posedge clk); #1;
      iv[0] = 1'b0; rst = 1'b1;
      @(posedge clk); #1;
      chk("rst mid-busy out_valid", 128'(ov[0]), 128'd0);
      chk("rst mid-busy busy", 128'(bsy[0]), 128'd0);
      chk("rst mid-busy data_out", dout[0], 128'd0);
      chk("rst mid-busy in_ready", 128'(ir[0]), 128'd0);
      rst = 1'b0;
      #1;
      chk("rst released in_ready", 128'(ir[0]), 128'd1);

      // Bypass with held-off output; a second request must be ignored.
      d = rnd128();
      @(posedge clk); #1;
      iv[0] = 1'b1; md[0] = 2'b10; din[0] = d; ordy[0] = 1'b0;
      @(posedge clk); #1;
      din[0] = ~d; md[0] = 2'b00;
      wcnt = 0;
      while (!ov[0] && wcnt < 10) begin
         @(posedge clk); #1;
         wcnt++;
      end
      chk("bypass latency", 128'(wcnt), 128'd4);
      for (int c = 0; c < 10; c++) begin
         chk("bypass hold out_valid", 128'(ov[0]), 128'd1);
         chk("bypass hold in_ready", 128'(ir[0]), 128'd0);
         chk("bypass hold data_out", dout[0], d);
         @(posedge clk); #1;
      end
      iv[0] = 1'b0; ordy[0] = 1'b1;
      @(posedge clk); #1;
      chk("bypass drained out_valid", 128'(ov[0]), 128'd0);
      chk("bypass drained busy", 128'(bsy[0]), 128'd0);

      // Back-to-back, mode alternating.
      fork
         run_stream(0, 20, 1'b0);
         run_stream(1, 20, 1'b0);
         run_stream(2, 20, 1'b0);
      join

      // Randomised traffic, 10k blocks total.
      fork
         run_stream(0, 3334, 1'b1);
         run_stream(1, 3333, 1'b1);
         run_stream(2, 3333, 1'b1);
      join

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
